elbeth_pipeline_control: RTL and testbench
==========================================

Name: elbeth_pipeline_control

Overview:
Central stall/flush sequencer for the ELBETH 5-stage pipeline (IF, ID, EX, MEM, WB).
- Generates per-register stall/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC hold.
- Resolves hazards by fixed priority, sequences the multi-cycle divider, and redirects to the exception vector.
- Outputs feed the pipeline registers directly. Those registers give stall priority over flush, so this block never asserts stall and flush on the same register in the same cycle.

Parameters:
DIV_CYCLES, 32, cycles the divider needs; legal range 2..255.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_imem_busy  in  1  instruction memory has not returned this cycle
mem_dmem_busy  in  1  data memory access in MEM not complete
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_rt  in  5  destination of the EX instruction
ex_mem_read  in  1  EX instruction is a load
id_branch_taken  in  1  branch/jump resolved taken in ID (no delay slot)
ex_div_start  in  1  level; a div/divu sits in EX
mem_except  in  1  level; instruction in MEM raises an exception
pc_stall  out  1  hold PC
if_id_stall, if_id_flush  out  1 each
id_ex_stall, id_ex_flush  out  1 each
ex_mem_stall, ex_mem_flush  out  1 each
mem_wb_stall, mem_wb_flush  out  1 each  (mem_wb_stall is always 0)
exc_pc_sel  out  1  PC loads the exception vector this cycle
div_busy  out  1  divider running
div_done  out  1  divider result valid this cycle

Behaviour:
- FSM states RUN, DIV, DONE; down-counter cnt, 8 bits. All outputs are combinational from state, cnt and inputs. Only state and cnt are registered.
- Reset (rst=0, async): state=RUN, cnt=0. All outputs read 0 while in reset.
- load_use = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Stall/flush selection, highest priority first; everything not listed is 0:
  1. mem_except & (mem_dmem_busy | if_imem_busy): pc, if_id, id_ex, ex_mem stalled; mem_wb_flush.
  2. mem_except, no busy: if_id/id_ex/ex_mem/mem_wb flush; exc_pc_sel=1; no stalls. Next state RUN, cnt=0; this aborts any DIV/DONE.
  3. mem_dmem_busy: pc, if_id, id_ex, ex_mem stalled; mem_wb_flush.
  4. state==DIV: pc, if_id, id_ex stalled; ex_mem_flush.
  5. if_imem_busy: pc, if_id stalled; id_ex_flush. A taken branch waits in ID and re-resolves later.
  6. load_use: pc, if_id stalled; id_ex_flush.
  7. id_branch_taken: if_id_flush; pc not stalled, so the branch target loads.
- FSM transitions:
  - RUN -> DIV when ex_div_start and rule 1/2 inactive; cnt <= DIV_CYCLES-1. The start cycle itself counts as DIV cycle 1: apply rule 4 in that cycle and assert div_busy.
  - DIV: div_busy=1; cnt decrements every cycle, regardless of rule 3. At cnt==0 go to DONE.
  - DIV therefore lasts exactly DIV_CYCLES cycles including the start cycle.
  - DONE: div_done=1; ex_div_start is ignored. Stay while id_ex_stall=1; go to RUN on the first cycle with id_ex_stall=0, when the div leaves EX.
- ex_div_start is ignored in DIV and DONE.
- A reset assertion mid-DIV returns to RUN immediately; no div_done is produced.

Decomposition:
- elbeth_definitions.v gains `PCTL_RUN, `PCTL_DIV, `PCTL_DONE state encodings (2 bits) and the default `DIV_CYCLES.
- No sub-module. The hazard comparator is small enough to stay inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only. Repeat with ex_rt=0 -> no stall.
- dmem stall: mem_dmem_busy high 3 cycles with load_use also true -> pc/if_id/id_ex/ex_mem stall and mem_wb_flush for 3 cycles; id_ex_flush stays 0.
- Divide: ex_div_start held, DIV_CYCLES=32 -> div_busy=1 for exactly 32 cycles with ex_mem_flush=1. Then div_done=1 for 1 cycle and no restart. With dmem busy during DONE, div_done persists until the release.
- Exception while dmem busy: mem_except=1, mem_dmem_busy=1 for 2 cycles then 0 -> 2 cycles of full stall, then 1 cycle of all four flushes with exc_pc_sel=1.
- Exception mid-DIV at cycle 10 -> flush cycle with exc_pc_sel=1, div_busy=0 next cycle, div_done never asserted.
- Branch and reset: id_branch_taken with if_imem_busy=1 -> pc/if_id stall, no if_id_flush; when imem is released -> if_id_flush=1, pc_stall=0. Async rst low mid-DIV -> all outputs 0 immediately; RUN after release.

Source files
------------

// File: rtl/elbeth_pipeline_control_pkg.sv
// Shared definitions for the ELBETH pipeline stall/flush sequencer:
// state encodings, the default divider latency and the load-use comparator.
package elbeth_pipeline_control_pkg;

  typedef enum logic [1:0] {
    PCTL_RUN  = 2'd0,
    PCTL_DIV  = 2'd1,
    PCTL_DONE = 2'd2
  } pctl_state_t;

  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  // A load in EX feeding a source register of the instruction in ID; r0 never hazards.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/elbeth_pipeline_control.sv
// Central stall/flush sequencer for the 5-stage ELBETH pipeline: fixed-priority
// hazard resolution, multi-cycle divider sequencing and exception redirect.
module elbeth_pipeline_control
  import elbeth_pipeline_control_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_imem_busy,
  input  logic       mem_dmem_busy,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  input  logic       id_branch_taken,
  input  logic       ex_div_start,
  input  logic       mem_except,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       ex_mem_flush,
  output logic       mem_wb_stall,
  output logic       mem_wb_flush,
  output logic       exc_pc_sel,
  output logic       div_busy,
  output logic       div_done
);

  pctl_state_t state;
  logic [7:0]  cnt;

  logic load_use;
  logic exc_wait;
  logic exc_take;
  logic div_start;
  logic div_active;

  assign load_use   = is_load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
  assign exc_wait   = mem_except && (mem_dmem_busy || if_imem_busy);
  assign exc_take   = mem_except && !mem_dmem_busy && !if_imem_busy;
  // The start cycle already behaves as the first divider cycle.
  assign div_start  = (state == PCTL_RUN) && ex_div_start && !mem_except;
  assign div_active = (state == PCTL_DIV) || div_start;

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_stall = 1'b0;
    mem_wb_flush = 1'b0;
    exc_pc_sel   = 1'b0;
    div_busy     = 1'b0;
    div_done     = 1'b0;
    if (rst) begin
      div_busy = div_active;
      div_done = (state == PCTL_DONE);
      if (exc_wait || mem_dmem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (exc_take) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        exc_pc_sel   = 1'b1;
      end else if (div_active) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (if_imem_busy || load_use) begin
        // A taken branch in ID simply waits here and re-resolves later.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (id_branch_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PCTL_RUN;
      cnt   <= 8'd0;
    end else if (exc_take) begin
      state <= PCTL_RUN;
      cnt   <= 8'd0;
    end else begin
      case (state)
        PCTL_RUN: begin
          if (div_start) begin
            state <= PCTL_DIV;
            cnt   <= 8'(DIV_CYCLES - 1);
          end
        end
        PCTL_DIV: begin
          // Leave as cnt reaches 0 so DIV spans DIV_CYCLES cycles with the start cycle.
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= PCTL_DONE;
        end
        PCTL_DONE: begin
          if (!id_ex_stall) state <= PCTL_RUN;
        end
        default: begin
          state <= PCTL_RUN;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_pipeline_control.sv
// Directed bench for elbeth_pipeline_control: hand-computed output vectors
// checked with immediate assertions one cycle at a time.
module tb_elbeth_pipeline_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_imem_busy, mem_dmem_busy, id_uses_rt, ex_mem_read;
  logic       id_branch_taken, ex_div_start, mem_except;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
  logic       exc_pc_sel, div_busy, div_done;

  int checks = 0;
  int errors = 0;

  // Output vector order:
  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
  //  ex_mem_flush, mem_wb_stall, mem_wb_flush, exc_pc_sel, div_busy, div_done}
  localparam logic [11:0] V_NONE  = 12'h000;
  localparam logic [11:0] V_LU    = 12'hC80;
  localparam logic [11:0] V_FULL  = 12'hD48;
  localparam logic [11:0] V_EXC   = 12'h2AC;
  localparam logic [11:0] V_DIV   = 12'hD22;
  localparam logic [11:0] V_BR    = 12'h200;
  localparam logic [11:0] V_DONE  = 12'h001;

  elbeth_pipeline_control #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .if_imem_busy(if_imem_busy), .mem_dmem_busy(mem_dmem_busy),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .id_branch_taken(id_branch_taken), .ex_div_start(ex_div_start),
    .mem_except(mem_except),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .exc_pc_sel(exc_pc_sel), .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    #1;
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           ex_mem_flush, mem_wb_stall, mem_wb_flush, exc_pc_sel, div_busy, div_done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_imem_busy = 0; mem_dmem_busy = 0; id_uses_rt = 0; ex_mem_read = 0;
    id_branch_taken = 0; ex_div_start = 0; mem_except = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    mem_dmem_busy = 1; ex_div_start = 1; id_branch_taken = 1;
    check("reset_outputs", V_NONE);
    #20;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("idle_after_reset", V_NONE);

    // Load-use via rs, then r0, then via rt
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    check("load_use_rs", V_LU);
    tick();
    clear_inputs();
    check("load_use_gone", V_NONE);
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    check("load_use_r0", V_NONE);
    tick();
    ex_rt = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1;
    check("load_use_rt", V_LU);
    id_uses_rt = 0;
    check("load_use_rt_unused", V_NONE);
    tick();

    // dmem busy beats load-use for 3 cycles
    ex_rt = 5; id_rs = 5; mem_dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dmem_stall_%0d", i), V_FULL);
      tick();
    end
    clear_inputs();
    check("dmem_released", V_NONE);
    tick();

    // Divide: 32 busy cycles, one done cycle, start ignored while DONE
    ex_div_start = 1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("div_busy_%0d", i), V_DIV);
      tick();
    end
    check("div_done", V_DONE);
    tick();
    ex_div_start = 0;
    check("div_no_restart", V_NONE);
    tick();

    // Divide again, dmem busy during DONE keeps div_done up
    ex_div_start = 1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("div2_busy_%0d", i), V_DIV);
      tick();
    end
    mem_dmem_busy = 1;
    check("div2_done_held_0", V_FULL | V_DONE);
    tick();
    check("div2_done_held_1", V_FULL | V_DONE);
    tick();
    mem_dmem_busy = 0;
    check("div2_done_release", V_DONE);
    ex_div_start = 0;
    tick();
    check("div2_back_to_run", V_NONE);
    tick();

    // Exception waits for dmem, then flushes and redirects
    mem_except = 1; mem_dmem_busy = 1;
    check("exc_wait_0", V_FULL);
    tick();
    check("exc_wait_1", V_FULL);
    tick();
    mem_dmem_busy = 0;
    check("exc_take", V_EXC);
    tick();
    mem_except = 0;
    check("exc_after", V_NONE);
    tick();

    // Exception at divider cycle 10 aborts the divide
    ex_div_start = 1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("div3_busy_%0d", i), V_DIV);
      tick();
    end
    ex_div_start = 0; mem_except = 1;
    check("div3_exc", V_EXC | 12'h002);
    tick();
    mem_except = 0;
    for (int i = 0; i < 30; i++) begin
      check($sformatf("div3_aborted_%0d", i), V_NONE);
      tick();
    end

    // Taken branch blocked by imem busy, then redirects
    id_branch_taken = 1; if_imem_busy = 1;
    check("branch_imem_busy", V_LU);
    tick();
    if_imem_busy = 0;
    check("branch_taken", V_BR);
    tick();
    clear_inputs();

    // Async reset mid-divide
    ex_div_start = 1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("div4_busy_%0d", i), V_DIV);
      tick();
    end
    ex_div_start = 0;
    #2;
    rst = 1'b0;
    check("reset_mid_div", V_NONE);
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("run_after_reset", V_NONE);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
